// File: rtl/dcache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_controller
// Purpose  : MEM-stage data-cache miss handler: dirty-victim writeback,
//            word-by-word line refill over req/ack, then tag install.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_miss_controller #(
    parameter int LINE_WORDS    = 4,
    parameter int WORD_IDX_BITS = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemAccessM,
    input  logic                     HitM,
    input  logic                     DirtyM,
    input  logic [31:0]              AddrM,
    input  logic [31:0]              VictimAddrM,
    input  logic [31:0]              victim_rdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic                     StallM,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [WORD_IDX_BITS-1:0] victim_word_idx,
    output logic                     refill_we,
    output logic [WORD_IDX_BITS-1:0] refill_word_idx,
    output logic [31:0]              refill_data,
    output logic                     tag_we
);

    localparam int                       c_OFFSET_BITS = WORD_IDX_BITS + 2;
    localparam logic [WORD_IDX_BITS-1:0] c_LAST_BEAT   = WORD_IDX_BITS'(LINE_WORDS - 1);
    localparam logic [WORD_IDX_BITS-1:0] c_BEAT_ONE    = WORD_IDX_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_INSTALL   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [WORD_IDX_BITS-1:0] r_beat;
    logic [31:0]              r_miss_line;
    logic [31:0]              r_victim_line;

    logic                     w_miss;
    logic                     w_last_beat;
    logic [31:0]              w_beat_offset;
    logic                     w_unused_offset_bits;

    assign w_miss               = MemAccessM & ~HitM;
    assign w_last_beat          = (r_beat == c_LAST_BEAT);
    assign w_beat_offset        = 32'({r_beat, 2'b00});
    assign w_unused_offset_bits = ^AddrM[c_OFFSET_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_miss_line   <= '0;
            r_victim_line <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_miss_line   <= {AddrM[31:c_OFFSET_BITS], {c_OFFSET_BITS{1'b0}}};
                        r_victim_line <= VictimAddrM;
                        r_beat        <= '0;
                        r_state       <= DirtyM ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= S_REFILL;
                        end else begin
                            r_beat  <= r_beat + c_BEAT_ONE;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_beat <= r_beat + c_BEAT_ONE;
                        if (w_last_beat) begin
                            r_state <= S_INSTALL;
                        end
                    end
                end
                S_INSTALL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are combinational so the stall and refill write land in the
    // same cycle as the miss / ack; reset overrides everything.
    always_comb begin
        StallM          = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        victim_word_idx = '0;
        refill_we       = 1'b0;
        refill_word_idx = '0;
        refill_data     = '0;
        tag_we          = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    StallM = w_miss;
                end
                S_WRITEBACK: begin
                    StallM          = 1'b1;
                    mem_req         = 1'b1;
                    mem_we          = 1'b1;
                    mem_addr        = r_victim_line + w_beat_offset;
                    victim_word_idx = r_beat;
                    mem_wdata       = victim_rdata;
                end
                S_REFILL: begin
                    StallM   = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = r_miss_line + w_beat_offset;
                    if (mem_ack) begin
                        refill_we       = 1'b1;
                        refill_word_idx = r_beat;
                        refill_data     = mem_rdata;
                    end
                end
                S_INSTALL: begin
                    StallM = 1'b1;
                    tag_we = 1'b1;
                end
                default: begin
                    StallM = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_controller
// Purpose  : Directed bench with a transaction-queue model of the miss flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_controller;

    localparam int LW  = 4;
    localparam int WIB = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            MemAccessM, HitM, DirtyM;
    logic [31:0]     AddrM, VictimAddrM, victim_rdata, mem_rdata;
    logic            mem_ack;
    logic            StallM, mem_req, mem_we, refill_we, tag_we;
    logic [31:0]     mem_addr, mem_wdata, refill_data;
    logic [WIB-1:0]  victim_word_idx, refill_word_idx;

    logic            flush;
    logic            stray;
    logic            cached_valid;
    logic [27:0]     cached_tag;
    int              ack_period;

    int              checks = 0;
    int              errors = 0;
    int              stall_cnt, refill_cnt, tag_cnt, req_cnt;
    logic [31:0]     acked_addr[$];
    logic [31:0]     acked_wdata[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  idx;
    } beat_t;
    beat_t q[$];
    bit    inst_pend;

    dcache_miss_controller #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .MemAccessM(MemAccessM), .HitM(HitM), .DirtyM(DirtyM),
        .AddrM(AddrM), .VictimAddrM(VictimAddrM), .victim_rdata(victim_rdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .StallM(StallM), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .victim_word_idx(victim_word_idx), .refill_we(refill_we),
        .refill_word_idx(refill_word_idx), .refill_data(refill_data), .tag_we(tag_we)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] victim_word(input logic [1:0] i);
        return 32'hD00D_0000 | {30'd0, i};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Environment: victim line storage, main memory and a one-line tag store.
    assign victim_rdata = victim_word(victim_word_idx);
    assign mem_rdata    = mem_word(mem_addr);
    assign HitM         = cached_valid && (AddrM[31:4] == cached_tag);

    always @(posedge clk) begin
        if (rst || flush) begin
            cached_valid <= 1'b0;
        end else if (tag_we) begin
            cached_valid <= 1'b1;
            cached_tag   <= AddrM[31:4];
        end
    end

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (wait_cnt == ack_period - 1) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                mem_ack  = stray;
                wait_cnt = 0;
            end
        end
    end

    // Model: a miss expands into a list of beats; each ack retires one beat,
    // and an empty list after the last beat means one install cycle.
    initial begin
        logic [104:0] act, exp;
        logic         e_stall, e_req, e_we, e_rwe, e_tag;
        logic [31:0]  e_addr, e_wdata, e_rdata;
        logic [1:0]   e_vidx, e_ridx;
        beat_t        h, b;
        inst_pend = 1'b0;
        forever begin
            @(negedge clk);
            {e_stall, e_req, e_we, e_rwe, e_tag} = '0;
            {e_addr, e_wdata, e_rdata, e_vidx, e_ridx} = '0;
            if (rst) begin
                q.delete();
                inst_pend = 1'b0;
            end else if (q.size() > 0) begin
                h       = q[0];
                e_stall = 1'b1;
                e_req   = 1'b1;
                e_we    = h.we;
                e_addr  = h.addr;
                if (h.we) begin
                    e_wdata = h.wdata;
                    e_vidx  = h.idx;
                end else if (mem_ack) begin
                    e_rwe   = 1'b1;
                    e_ridx  = h.idx;
                    e_rdata = mem_word(h.addr);
                end
                if (mem_ack) begin
                    void'(q.pop_front());
                    if (q.size() == 0) inst_pend = 1'b1;
                end
            end else if (inst_pend) begin
                e_stall   = 1'b1;
                e_tag     = 1'b1;
                inst_pend = 1'b0;
            end else begin
                e_stall = MemAccessM & ~HitM;
                if (e_stall) begin
                    for (int k = 0; k < LW; k++) begin
                        if (DirtyM) begin
                            b.we = 1'b1; b.addr = VictimAddrM + 32'(4 * k);
                            b.idx = k[1:0]; b.wdata = victim_word(k[1:0]);
                            q.push_back(b);
                        end
                    end
                    for (int k = 0; k < LW; k++) begin
                        b.we = 1'b0; b.addr = {AddrM[31:4], 4'h0} + 32'(4 * k);
                        b.idx = k[1:0]; b.wdata = 32'h0;
                        q.push_back(b);
                    end
                end
            end
            exp = {e_stall, e_req, e_we, e_addr, e_wdata, e_vidx, e_rwe, e_ridx, e_rdata, e_tag};
            act = {StallM, mem_req, mem_we, mem_addr, mem_wdata, victim_word_idx,
                   refill_we, refill_word_idx, refill_data, tag_we};
            checks = checks + 1;
            if (act !== exp) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, exp);
            end
            if (StallM) stall_cnt = stall_cnt + 1;
            if (refill_we) refill_cnt = refill_cnt + 1;
            if (tag_we) tag_cnt = tag_cnt + 1;
            if (mem_req) req_cnt = req_cnt + 1;
            if (mem_req && mem_ack) begin
                acked_addr.push_back(mem_addr);
                acked_wdata.push_back(mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        stall_cnt = 0; refill_cnt = 0; tag_cnt = 0; req_cnt = 0;
        acked_addr.delete();
        acked_wdata.delete();
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic [31:0] victim,
                            input logic dirty, input int period, input logic scramble);
        bit done;
        done = 1'b0;
        tick();
        ack_period  = period;
        MemAccessM  = 1'b1;
        AddrM       = addr;
        VictimAddrM = victim;
        DirtyM      = dirty;
        clear_counts();
        if (scramble) begin
            tick();
            VictimAddrM = 32'hDEAD_BEE0;
            DirtyM      = ~dirty;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!StallM) begin
                done = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL miss_timeout actual=stalled required=released");
        end
        tick();
        MemAccessM = 1'b0;
        DirtyM     = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        rst = 1'b1; flush = 1'b0; stray = 1'b0; ack_period = 1;
        MemAccessM = 1'b0; DirtyM = 1'b0; AddrM = 32'h0; VictimAddrM = 32'h0;
        clear_counts();
        repeat (3) tick();
        check_val("reset_stall", {31'd0, StallM}, 32'd0);
        check_val("reset_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;

        // Spurious acks while idle
        clear_counts();
        stray = 1'b1;
        repeat (3) tick();
        stray = 1'b0;
        tick();
        check_val("spurious_refill", 32'(refill_cnt), 32'd0);
        check_val("spurious_tag", 32'(tag_cnt), 32'd0);

        // Clean miss, ack every cycle
        run_miss(32'h0000_1234, 32'h0, 1'b0, 1, 1'b0);
        check_val("clean_stall_len", 32'(stall_cnt), 32'd6);
        check_val("clean_refills", 32'(refill_cnt), 32'd4);
        check_val("clean_tag", 32'(tag_cnt), 32'd1);
        check_val("clean_beats", 32'(acked_addr.size()), 32'd4);
        if (acked_addr.size() == 4) begin
            check_val("clean_addr0", acked_addr[0], 32'h0000_1230);
            check_val("clean_addr3", acked_addr[3], 32'h0000_123C);
        end

        // Hit traffic
        clear_counts();
        MemAccessM = 1'b1;
        for (int i = 0; i < 20; i++) begin
            AddrM = 32'h0000_1230 + 32'(4 * (i % 4));
            tick();
        end
        MemAccessM = 1'b0;
        tick();
        check_val("hit_stall", 32'(stall_cnt), 32'd0);
        check_val("hit_req", 32'(req_cnt), 32'd0);
        check_val("hit_tag", 32'(tag_cnt), 32'd0);

        // Dirty miss with victim inputs changing mid-transaction
        flush = 1'b1; tick(); flush = 1'b0;
        run_miss(32'h0000_1234, 32'h0000_8230, 1'b1, 1, 1'b1);
        check_val("dirty_stall_len", 32'(stall_cnt), 32'd10);
        check_val("dirty_refills", 32'(refill_cnt), 32'd4);
        check_val("dirty_beats", 32'(acked_addr.size()), 32'd8);
        if (acked_addr.size() == 8) begin
            check_val("dirty_wr_addr0", acked_addr[0], 32'h0000_8230);
            check_val("dirty_wr_addr3", acked_addr[3], 32'h0000_823C);
            check_val("dirty_rd_addr0", acked_addr[4], 32'h0000_1230);
            check_val("dirty_wdata0", acked_wdata[0], 32'hD00D_0000);
            check_val("dirty_wdata3", acked_wdata[3], 32'hD00D_0003);
        end

        // Slow memory, ack every third cycle
        flush = 1'b1; tick(); flush = 1'b0;
        run_miss(32'h0000_2468, 32'h0, 1'b0, 3, 1'b0);
        check_val("slow_stall_len", 32'(stall_cnt), 32'd14);
        check_val("slow_req_cycles", 32'(req_cnt), 32'd12);
        if (acked_addr.size() == 4)
            check_val("slow_addr1", acked_addr[1], 32'h0000_2464);
        else
            check_val("slow_beats", 32'(acked_addr.size()), 32'd4);

        // Reset after the second refill ack, then stray acks
        tick();
        ack_period = 1;
        MemAccessM = 1'b1;
        AddrM      = 32'h0000_4008;
        DirtyM     = 1'b0;
        clear_counts();
        done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (refill_cnt >= 2) begin
                done = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL midrst_timeout actual=%0d required=2", refill_cnt);
        end
        tick();
        rst = 1'b1; MemAccessM = 1'b0; stray = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        stray = 1'b0;
        tick();
        check_val("midrst_refills", 32'(refill_cnt), 32'd2);
        check_val("midrst_tag", 32'(tag_cnt), 32'd0);
        check_val("midrst_stall", {31'd0, StallM}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
